// File: rtl/esc_pkg.sv
// esc_pkg: constants and FSM state type shared by the ESC PWM transmitter,
// the decoder and benches.
package esc_pkg;

  localparam int ESC_MIN_CLKS     = 6250;
  localparam int ESC_CLKS_PER_LSB = 3;
  localparam int ESC_SPEED_W      = 11;
  localparam int ESC_SHORT_TOL    = 4;
  localparam int ESC_LONG_SLACK   = 16;

  localparam logic [ESC_SPEED_W-1:0] ESC_SPEED_FULL = '1;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    MIN  = 2'd2,
    SPD  = 2'd3
  } esc_state_e;

endpackage

// File: rtl/esc_pwm_sync.sv
// esc_pwm_sync: 2-flop synchronizer plus a third flop for edge detect.
// Both edges see the same latency, so measured widths are exact.
module esc_pwm_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= {3{RST_VAL}};
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign q_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/esc_pwm_decoder.sv
// esc_pwm_decoder: recovers SPEED from the high time of an ESC PWM pulse.
// Division by CLKS_PER_LSB comes from a wrapping prescaler, not a divider.
module esc_pwm_decoder
  import esc_pkg::*;
#(
  parameter int MIN_CLKS     = ESC_MIN_CLKS,
  parameter int CLKS_PER_LSB = ESC_CLKS_PER_LSB,
  parameter int SPEED_W      = ESC_SPEED_W,
  parameter int SHORT_TOL    = ESC_SHORT_TOL,
  parameter int LONG_SLACK   = ESC_LONG_SLACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PWM,
  output logic [SPEED_W-1:0] SPEED,
  output logic               vld,
  output logic               err_short,
  output logic               err_long
);

  localparam int BASE_W  = $clog2(MIN_CLKS + 1);
  localparam int PRE_W   = (CLKS_PER_LSB > 1) ?
                           $clog2(CLKS_PER_LSB) : 1;
  localparam int SLACK_W = (LONG_SLACK > 0) ?
                           $clog2(LONG_SLACK + 1) : 1;

  localparam logic [BASE_W-1:0] BASE_LAST =
    BASE_W'(MIN_CLKS - 1);
  localparam logic [BASE_W-1:0] BASE_OK =
    BASE_W'(MIN_CLKS - SHORT_TOL);
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(CLKS_PER_LSB - 1);
  localparam logic [SLACK_W-1:0] SLACK_LIM =
    SLACK_W'(LONG_SLACK);
  localparam logic [SPEED_W-1:0] SPD_FULL = '1;

  logic pwm_s;
  logic rise;
  logic fall;

  // Preset high so a pulse already in progress at reset release
  // looks stuck-high to ARM instead of producing a false rise.
  esc_pwm_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (PWM),
    .q_o   (pwm_s),
    .rise_o(rise),
    .fall_o(fall)
  );

  esc_state_e         state_q, state_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic [SLACK_W-1:0] slack_q, slack_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               vld_q, vld_d;
  logic               es_q, es_d;
  logic               el_q, el_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    pre_d   = pre_q;
    spd_d   = spd_q;
    slack_d = slack_q;
    speed_d = speed_q;
    vld_d   = 1'b0;
    es_d    = 1'b0;
    el_d    = 1'b0;
    unique case (state_q)
      ARM: begin
        if (!pwm_s) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          base_d  = BASE_W'(1);
          pre_d   = '0;
          spd_d   = '0;
          slack_d = '0;
          state_d = MIN;
        end
      end
      MIN: begin
        if (fall) begin
          state_d = IDLE;
          if (base_q >= BASE_OK) begin
            speed_d = '0;
            vld_d   = 1'b1;
          end else begin
            es_d = 1'b1;
          end
        end else if (base_q == BASE_LAST) begin
          pre_d   = '0;
          spd_d   = '0;
          state_d = SPD;
        end else begin
          base_d = base_q + BASE_W'(1);
        end
      end
      SPD: begin
        if (fall) begin
          speed_d = spd_q;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (spd_q != SPD_FULL) spd_d = spd_q + SPEED_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
          if (spd_q == SPD_FULL) begin
            if (slack_q == SLACK_LIM) begin
              speed_d = SPD_FULL;
              el_d    = 1'b1;
              state_d = ARM;
            end else begin
              slack_d = slack_q + SLACK_W'(1);
            end
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARM;
      base_q  <= '0;
      pre_q   <= '0;
      spd_q   <= '0;
      slack_q <= '0;
      speed_q <= '0;
      vld_q   <= 1'b0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pre_q   <= pre_d;
      spd_q   <= spd_d;
      slack_q <= slack_d;
      speed_q <= speed_d;
      vld_q   <= vld_d;
      es_q    <= es_d;
      el_q    <= el_d;
    end
  end

  assign SPEED     = speed_q;
  assign vld       = vld_q;
  assign err_short = es_q;
  assign err_long  = el_q;

endmodule

// File: doc/esc_pwm_decoder.md
Name: esc_pwm_decoder

Overview:
- Receive end of the ESC PWM link: measures the high time of an incoming ESC-style PWM pulse and recovers the 11-bit SPEED word that produced it.
- Encoding decoded: high time = MIN_CLKS + CLKS_PER_LSB*SPEED clocks.
- Used as the ESC/motor model in quadcopter benches and as a loopback checker for the PWM transmitter.
- Emits a one-cycle valid strobe plus error flags per pulse.

Parameters:
- MIN_CLKS, 6250, high clocks encoding SPEED=0
- CLKS_PER_LSB, 3, extra high clocks per SPEED LSB
- SPEED_W, 11, width of recovered speed
- SHORT_TOL, 4, pulses this many clocks short of MIN_CLKS still decode as 0 without error
- LONG_SLACK, 16, clocks beyond full-scale width before declaring a stuck-high error

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- PWM  input  1  ESC PWM line, asynchronous to clk
- SPEED  output  SPEED_W  last decoded speed, held between pulses
- vld  output  1  one-clock strobe: new SPEED captured
- err_short  output  1  one-clock strobe: pulse shorter than MIN_CLKS-SHORT_TOL
- err_long  output  1  one-clock strobe: high exceeded MIN_CLKS+CLKS_PER_LSB*(2^SPEED_W-1)+LONG_SLACK

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: SPEED=0, vld=0, err_short=0, err_long=0, all counters 0, state ARM. Asserting rst_n mid-pulse aborts the measurement; no strobe is issued for that pulse.
- Input path: PWM passes through a 2-flop synchronizer and a third flop for edge detect. Rise = sync high and prev low; fall = sync low and prev high. Both edges carry the same latency, so measured width equals true width. Strobes appear 3 clocks after the real falling edge.
- FSM states:
  - ARM: wait for sync PWM low; go to IDLE. Guards against decoding a partial pulse already high out of reset or after err_long.
  - IDLE: on rise, clear counters and go to MIN.
  - MIN: base counter counts high clocks. At count MIN_CLKS go to SPD, prescaler=0, spd_cnt=0. On fall in MIN:
    - count >= MIN_CLKS-SHORT_TOL: SPEED=0, vld.
    - otherwise: err_short, SPEED unchanged, no vld.
    - Either way, back to IDLE.
  - SPD: mod-CLKS_PER_LSB prescaler. Each wrap increments spd_cnt, saturating at 2^SPEED_W-1. A slack counter runs once spd_cnt saturates.
    - On fall: SPEED=spd_cnt, vld, go to IDLE. Net result: SPEED = floor((N-MIN_CLKS)/CLKS_PER_LSB), where N is the high clock count.
    - Slack counter reaches LONG_SLACK with PWM still high: SPEED=2^SPEED_W-1, err_long, no vld, go to ARM.
- No divider is used. Division comes from the prescaler; counter widths come from $clog2 of the parameters.
- vld and err_* are mutually exclusive and never high for more than one clock.
- A rise arriving the clock after a fall is accepted: IDLE is re-entered on the fall cycle, so back-to-back pulses with 1-clock low time decode correctly.
- Glitch immunity is not provided beyond the synchronizer. A 1–2 clock high blip yields err_short.

Decomposition:
- Package esc_pkg: MIN_CLKS, CLKS_PER_LSB, full-scale SPEED constant, and the FSM state enum (ARM, IDLE, MIN, SPD). These are shared with the transmitter and benches.
- One sub-module, esc_pwm_sync: 2-flop synchronizer plus edge detect, outputting pwm_s, rise, fall. Reusable for other asynchronous inputs.

Test Plan:
- Loopback with the PWM transmitter: wrt with SPEED=0, 0x021, 0x7FF. Required: vld once per pulse, SPEED=0x000, 0x021, 0x7FF; no err_*.
- Direct drive high for 6248 clks. Required: vld, SPEED=0. High for 6245 clks: err_short, SPEED keeps prior value, no vld.
- High for 6250+3*100+2 = 6552 clks. Required: SPEED=100 (floor). High for 6553 clks: SPEED=101.
- Hold PWM high for 20000 clks. Required: err_long once at 6250+6141+16 high clocks (+3 latency), SPEED=0x7FF. Then lower and raise for 6250+3*5 clks: SPEED=5, vld; no decode of the stuck pulse's fall.
- PWM high at reset release: no vld on its fall. Next full pulse (SPEED 33 encoding) decodes to 0x021.
- rst_n asserted mid-pulse (10 clks into a SPEED=0 pulse): outputs 0 within #1, no vld for that pulse. Subsequent PWM low for 100 clks: vld and err_* stay 0.
